// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single core memory port between the instruction-fetch requester
// (IF) and the load/store requester (LS). One transaction is outstanding at a
// time: the winning request is registered onto the memory port, held until the
// memory grants it, and the response is routed back to whichever requester
// owns the transaction. A starvation counter guarantees that fetch wins after
// MAX_WAIT consecutive lost arbitrations, and a fetch-kill input lets the
// front end discard a stale fetch response after a redirect.
//
// Parameters
//   ADDR_W    address width shared by both requesters and memory
//   DATA_W    memory data width; must be 64 (fetch word chosen by addr[2])
//   MAX_WAIT  lost arbitrations after which a waiting fetch beats load/store
//
// Ports
//   clk, reset_n                 core clock, asynchronous active-low reset
//   if_req_i / if_addr_i         fetch request and PC, held until if_gnt_o
//   if_kill_i                    redirect: drop any in-flight fetch response
//   if_gnt_o / if_rvalid_o       fetch accept pulse / fetch data valid pulse
//   if_rdata_o                   32-bit instruction word
//   ls_req_i, ls_we_i, ls_addr_i,
//   ls_wdata_i, ls_be_i          load/store request, held until ls_gnt_o
//   ls_gnt_o / ls_rvalid_o       load/store accept pulse / data-or-ack pulse
//   ls_rdata_o                   full-width load data
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_be_o        registered memory request
//   mem_gnt_i                    memory accepts the request this cycle
//   mem_rvalid_i / mem_rdata_i   memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_kill_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [31:0]         if_rdata_o,

    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_WAIT);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT  = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;

    logic [1:0]       state;
    logic             owner_if;
    logic             killed;
    logic [CNT_W-1:0] starve_cnt;
    logic             any_req;
    logic             if_wins;
    logic             resp_cycle;

    // Load/store normally has priority because a stalled LSU blocks retirement;
    // fetch only overrides it once it has lost MAX_WAIT arbitrations in a row.
    assign any_req = if_req_i | ls_req_i;
    assign if_wins = if_req_i & (~ls_req_i | (starve_cnt == STARVE_MAX));

    // Transaction sequencer. The request is latched on arbitration and held
    // unchanged on the memory port until granted; a kill only marks the fetch
    // as stale so the memory handshake still completes normally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            owner_if    <= 1'b0;
            killed      <= 1'b0;
            starve_cnt  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_WAIT_GNT;
                        mem_req_o <= 1'b1;
                        killed    <= 1'b0;
                        owner_if  <= if_wins;
                        if (if_wins) begin
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                            mem_be_o    <= '0;
                            starve_cnt  <= '0;
                        end else begin
                            mem_we_o    <= ls_we_i;
                            mem_addr_o  <= ls_addr_i;
                            mem_wdata_o <= ls_wdata_i;
                            mem_be_o    <= ls_be_i;
                            if (if_req_i && (starve_cnt != STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT_GNT: begin
                    if (if_kill_i && owner_if) begin
                        killed <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (if_kill_i && owner_if) begin
                        killed <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Grants and responses are steered combinationally to the owner so no
    // cycle is lost on either handshake. A kill arriving in the response cycle
    // itself must already hide that response, hence the direct if_kill_i term.
    assign resp_cycle  = (state == ST_WAIT_RESP) & mem_rvalid_i;
    assign if_gnt_o    = (state == ST_WAIT_GNT) & owner_if & mem_gnt_i;
    assign ls_gnt_o    = (state == ST_WAIT_GNT) & ~owner_if & mem_gnt_i;
    assign if_rvalid_o = resp_cycle & owner_if & ~killed & ~if_kill_i;
    assign ls_rvalid_o = resp_cycle & ~owner_if;

    // The fetch word is the half of the 64-bit beat selected by address bit 2.
    assign if_rdata_o = mem_addr_o[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    assign ls_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. The bench plays the part of both
// requesters and of the memory. A small reference model (pending requests plus
// a count of lost fetch arbitrations) predicts which requester owns each
// transaction and what must appear on the memory port and response paths.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              reset_n;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_kill_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic [7:0]        ls_be_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [7:0]        mem_be_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    // Reference model state: consecutive lost fetch arbitrations.
    int model_starve = 0;

    // Observations of the most recent transaction.
    bit                obs_timeout;
    int                obs_lat;
    int                obs_if_gnt, obs_ls_gnt, obs_if_rv, obs_ls_rv;
    int                obs_unstable, obs_req_bad;
    logic [31:0]       obs_if_rdata;
    logic [DATA_W-1:0] obs_ls_rdata;
    logic              obs_we;
    logic [ADDR_W-1:0] obs_addr;
    logic [DATA_W-1:0] obs_wdata;
    logic [7:0]        obs_be;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_kill_i   (if_kill_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_be_i     (ls_be_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch wins when it is the only requester or has been starved to the limit.
    function automatic bit model_pick_if(input bit ir, input bit lr);
        bit w;
        w = ir && (!lr || model_starve == MAX_WAIT);
        if (w) model_starve = 0;
        else if (ir && model_starve < MAX_WAIT) model_starve++;
        return w;
    endfunction

    function automatic logic [31:0] fetch_word(input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
        return a[2] ? d[63:32] : d[31:0];
    endfunction

    task automatic apply_reset();
        reset_n      = 1'b0;
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        if_kill_i    = 1'b0;
        ls_req_i     = 1'b0;
        ls_we_i      = 1'b0;
        ls_addr_i    = '0;
        ls_wdata_i   = '0;
        ls_be_i      = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n      = 1'b1;
        model_starve = 0;
    endtask

    // Plays memory for one transaction. Entered 1 time unit after a rising
    // edge with requests already driven; returns at the same phase once the
    // response has been delivered. Inputs are driven at edge+1, outputs are
    // sampled at edge+2. kill_at indexes the cycles after the request appears.
    task automatic do_txn(input int gnt_delay, input int rv_delay,
                          input logic [DATA_W-1:0] rdata, input int kill_at,
                          input bit keep_req);
        obs_timeout  = 1'b1;
        obs_lat      = 0;
        obs_if_gnt   = 0;
        obs_ls_gnt   = 0;
        obs_if_rv    = 0;
        obs_ls_rv    = 0;
        obs_unstable = 0;
        obs_req_bad  = 0;
        obs_if_rdata = '0;
        obs_ls_rdata = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (mem_req_o === 1'b1) begin
                obs_timeout = 1'b0;
                obs_lat     = c + 1;
                break;
            end
        end
        if (obs_timeout) return;
        obs_we    = mem_we_o;
        obs_addr  = mem_addr_o;
        obs_wdata = mem_wdata_o;
        obs_be    = mem_be_o;
        for (int g = 0; g <= gnt_delay; g++) begin
            mem_gnt_i    = (g == gnt_delay);
            if_kill_i    = (g == kill_at);
            mem_rvalid_i = 1'b0;
            #1;
            if (if_gnt_o === 1'b1) obs_if_gnt++;
            if (ls_gnt_o === 1'b1) obs_ls_gnt++;
            if (if_rvalid_o === 1'b1) obs_if_rv++;
            if (ls_rvalid_o === 1'b1) obs_ls_rv++;
            if (mem_req_o !== 1'b1 || mem_we_o !== obs_we || mem_addr_o !== obs_addr ||
                mem_wdata_o !== obs_wdata || mem_be_o !== obs_be)
                obs_unstable++;
            if (g == gnt_delay && !keep_req) begin
                if (if_gnt_o === 1'b1) if_req_i = 1'b0;
                if (ls_gnt_o === 1'b1) ls_req_i = 1'b0;
            end
            @(posedge clk);
            #1;
            mem_gnt_i = 1'b0;
            if_kill_i = 1'b0;
        end
        for (int r = 1; r <= rv_delay; r++) begin
            mem_rvalid_i = (r == rv_delay);
            mem_rdata_i  = (r == rv_delay) ? rdata : {$urandom, $urandom};
            if_kill_i    = (gnt_delay + r == kill_at);
            #1;
            if (mem_req_o !== 1'b0) obs_req_bad++;
            if (if_gnt_o === 1'b1) obs_if_gnt++;
            if (ls_gnt_o === 1'b1) obs_ls_gnt++;
            if (if_rvalid_o === 1'b1) begin
                obs_if_rv++;
                obs_if_rdata = if_rdata_o;
            end
            if (ls_rvalid_o === 1'b1) begin
                obs_ls_rv++;
                obs_ls_rdata = ls_rdata_o;
            end
            @(posedge clk);
            #1;
            mem_rvalid_i = 1'b0;
            if_kill_i    = 1'b0;
        end
    endtask

    // Reset values, then an asynchronous reset in the middle of a load response.
    task automatic test_reset();
        bit found;
        apply_reset();
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mem_port: got req=%b we=%b addr=%h wdata=%h be=%h, expected all 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
        end
        checks++;
        if ({if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshakes: got %b, expected 0000",
                     {if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o});
        end

        ls_req_i   = 1'b1;
        ls_we_i    = 1'b0;
        ls_addr_i  = 64'h3000;
        void'(model_pick_if(1'b0, 1'b1));
        found = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (mem_req_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reset_pre_req: mem_req_o never rose, expected 1");
        end
        mem_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt_i    = 1'b0;
        ls_req_i     = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h1234_5678_9ABC_DEF0;
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ls_rvalid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_resp_rvalid: got %b, expected 0", ls_rvalid_o);
        end
        checks++;
        if ({mem_req_o, mem_addr_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_resp_port: got req=%b addr=%h, expected 0",
                     mem_req_o, mem_addr_o);
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        model_starve = 0;
    endtask

    // Fetch-only transaction at 0x1004: upper word of the beat is returned.
    task automatic test_if_fetch();
        bit exp_if;
        if_req_i  = 1'b1;
        if_addr_i = 64'h1004;
        exp_if    = model_pick_if(1'b1, 1'b0);
        do_txn(0, 1, 64'hAAAA_BBBB_CCCC_DDDD, -1, 1'b0);
        checks++;
        if (obs_timeout || obs_lat != 1) begin
            errors++;
            $display("[TB] FAIL if_fetch_latency: timeout=%0b lat=%0d, expected lat 1", obs_timeout, obs_lat);
        end
        checks++;
        if (obs_if_gnt != (exp_if ? 1 : 0) || obs_ls_gnt != 0) begin
            errors++;
            $display("[TB] FAIL if_fetch_gnt: if_gnt=%0d ls_gnt=%0d, expected 1/0", obs_if_gnt, obs_ls_gnt);
        end
        checks++;
        if (obs_if_rv != 1 || obs_ls_rv != 0 || obs_if_rdata !== 32'hAAAA_BBBB) begin
            errors++;
            $display("[TB] FAIL if_fetch_resp: if_rv=%0d ls_rv=%0d rdata=%h, expected 1/0 aaaabbbb",
                     obs_if_rv, obs_ls_rv, obs_if_rdata);
        end
        checks++;
        if (obs_addr !== 64'h1004 || obs_we !== 1'b0 || obs_be !== 8'h00) begin
            errors++;
            $display("[TB] FAIL if_fetch_port: addr=%h we=%b be=%h, expected 1004/0/00",
                     obs_addr, obs_we, obs_be);
        end
    endtask

    // Both requesters held: fetch must break through after MAX_WAIT losses.
    task automatic test_starvation();
        bit exp_if;
        apply_reset();
        if_req_i   = 1'b1;
        if_addr_i  = 64'h0000_0000_0000_4000;
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b0;
        ls_addr_i  = 64'h0000_0000_0000_8008;
        for (int t = 0; t < 7; t++) begin
            exp_if = model_pick_if(1'b1, 1'b1);
            do_txn(0, 1, {$urandom, $urandom}, -1, 1'b1);
            checks++;
            if (obs_timeout || obs_if_gnt != (exp_if ? 1 : 0) || obs_ls_gnt != (exp_if ? 0 : 1) ||
                obs_addr !== (exp_if ? if_addr_i : ls_addr_i)) begin
                errors++;
                $display("[TB] FAIL starve_order[%0d]: if_gnt=%0d ls_gnt=%0d addr=%h, expected winner %s",
                         t, obs_if_gnt, obs_ls_gnt, obs_addr, exp_if ? "IF" : "LS");
            end
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
    endtask

    // Store with a slow grant: the request must stay frozen while waiting.
    task automatic test_store();
        bit exp_if;
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_addr_i  = 64'h0000_0000_0000_2010;
        ls_wdata_i = 64'h1122_3344_5566_7788;
        ls_be_i    = 8'h0F;
        exp_if     = model_pick_if(1'b0, 1'b1);
        do_txn(3, 1, 64'h0, -1, 1'b0);
        checks++;
        if (obs_timeout || obs_we !== 1'b1 || obs_addr !== 64'h2010 ||
            obs_wdata !== 64'h1122_3344_5566_7788 || obs_be !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL store_port: we=%b addr=%h wdata=%h be=%h, expected 1/2010/1122334455667788/0f",
                     obs_we, obs_addr, obs_wdata, obs_be);
        end
        checks++;
        if (obs_unstable != 0) begin
            errors++;
            $display("[TB] FAIL store_hold: %0d unstable cycles, expected 0", obs_unstable);
        end
        checks++;
        if (obs_ls_gnt != (exp_if ? 0 : 1) || obs_ls_rv != 1 || obs_if_gnt != 0 || obs_if_rv != 0) begin
            errors++;
            $display("[TB] FAIL store_handshake: ls_gnt=%0d ls_rv=%0d if_gnt=%0d if_rv=%0d, expected 1/1/0/0",
                     obs_ls_gnt, obs_ls_rv, obs_if_gnt, obs_if_rv);
        end
    endtask

    // Kill during WAIT_GNT and during the response cycle itself.
    task automatic test_kill();
        if_req_i  = 1'b1;
        if_addr_i = 64'h2000;
        void'(model_pick_if(1'b1, 1'b0));
        do_txn(2, 2, 64'hDEAD_BEEF_0BAD_F00D, 0, 1'b0);
        if_req_i = 1'b0;
        checks++;
        if (obs_timeout || obs_unstable != 0) begin
            errors++;
            $display("[TB] FAIL kill_gnt_hold: timeout=%0b unstable=%0d, expected 0/0", obs_timeout, obs_unstable);
        end
        checks++;
        if (obs_if_rv != 0 || obs_ls_rv != 0 || obs_ls_gnt != 0) begin
            errors++;
            $display("[TB] FAIL kill_gnt_rvalid: if_rv=%0d ls_rv=%0d ls_gnt=%0d, expected 0/0/0",
                     obs_if_rv, obs_ls_rv, obs_ls_gnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL kill_idle: mem_req_o=%b, expected 0", mem_req_o);
        end

        if_req_i  = 1'b1;
        if_addr_i = 64'h2008;
        void'(model_pick_if(1'b1, 1'b0));
        do_txn(0, 1, 64'h0123_4567_89AB_CDEF, 1, 1'b0);
        if_req_i = 1'b0;
        checks++;
        if (obs_timeout || obs_if_rv != 0) begin
            errors++;
            $display("[TB] FAIL kill_resp_cycle: timeout=%0b if_rv=%0d, expected 0/0", obs_timeout, obs_if_rv);
        end

        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 64'h5000;
        void'(model_pick_if(1'b0, 1'b1));
        do_txn(1, 1, 64'hFEED_FACE_CAFE_0001, -1, 1'b0);
        checks++;
        if (obs_timeout || obs_ls_rv != 1 || obs_ls_rdata !== 64'hFEED_FACE_CAFE_0001) begin
            errors++;
            $display("[TB] FAIL kill_followup: timeout=%0b ls_rv=%0d rdata=%h, expected 0/1/feedfacecafe0001",
                     obs_timeout, obs_ls_rv, obs_ls_rdata);
        end
    endtask

    // Responses arriving with no transaction outstanding must be ignored.
    task automatic test_spurious_rvalid();
        int bad;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = {$urandom, $urandom};
            #1;
            if (if_rvalid_o !== 1'b0 || ls_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        mem_rvalid_i = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL spurious_rvalid: %0d bad cycles, expected 0", bad);
        end
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 64'h6000;
        void'(model_pick_if(1'b0, 1'b1));
        do_txn(0, 2, 64'h7777_6666_5555_4444, -1, 1'b0);
        checks++;
        if (obs_timeout || obs_lat != 1 || obs_ls_gnt != 1 || obs_ls_rv != 1 ||
            obs_ls_rdata !== 64'h7777_6666_5555_4444) begin
            errors++;
            $display("[TB] FAIL spurious_followup: lat=%0d ls_gnt=%0d ls_rv=%0d rdata=%h, expected 1/1/1/7777666655554444",
                     obs_lat, obs_ls_gnt, obs_ls_rv, obs_ls_rdata);
        end
    endtask

    // Random mix: requests stay pending until served, arbitrary memory delays,
    // occasional kills (which only matter when fetch owns the transaction).
    task automatic test_random();
        bit                if_pend, ls_pend, exp_if, kill_on;
        logic [DATA_W-1:0] rdata;
        logic [31:0]       exp_word;
        int                gd, rd, ka, bad;
        if_pend = 1'b0;
        ls_pend = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (!if_pend && ($urandom_range(1, 0) == 1)) begin
                if_pend   = 1'b1;
                if_addr_i = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            end
            if (!ls_pend && ($urandom_range(1, 0) == 1 || !if_pend)) begin
                ls_pend    = 1'b1;
                ls_we_i    = $urandom_range(1, 0) == 1;
                ls_addr_i  = {$urandom, $urandom};
                ls_wdata_i = {$urandom, $urandom};
                ls_be_i    = 8'($urandom);
            end
            if_req_i = if_pend;
            ls_req_i = ls_pend;
            exp_if   = model_pick_if(if_pend, ls_pend);
            gd       = $urandom_range(3, 0);
            rd       = $urandom_range(3, 1);
            kill_on  = $urandom_range(3, 0) == 0;
            ka       = kill_on ? $urandom_range(gd + rd, 0) : -1;
            rdata    = {$urandom, $urandom};
            exp_word = fetch_word(if_addr_i, rdata);
            do_txn(gd, rd, rdata, ka, 1'b1);
            bad = 0;
            if (obs_timeout || obs_lat != 1 || obs_unstable != 0 || obs_req_bad != 0) bad++;
            if (exp_if) begin
                if (obs_ls_gnt != 0 || obs_ls_rv != 0) bad++;
                if (!kill_on && obs_if_gnt != 1) bad++;
                if (obs_if_rv != (kill_on ? 0 : 1)) bad++;
                if (!kill_on && obs_if_rdata !== exp_word) bad++;
                if (obs_addr !== if_addr_i || obs_we !== 1'b0 || obs_be !== 8'h00) bad++;
                if_pend = 1'b0;
            end else begin
                if (obs_if_gnt != 0 || obs_if_rv != 0 || obs_ls_gnt != 1 || obs_ls_rv != 1) bad++;
                if (obs_ls_rdata !== rdata) bad++;
                if (obs_addr !== ls_addr_i || obs_we !== ls_we_i ||
                    obs_wdata !== ls_wdata_i || obs_be !== ls_be_i) bad++;
                ls_pend = 1'b0;
            end
            if_req_i = if_pend;
            ls_req_i = ls_pend;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL random[%0d]: winner=%s kill=%0b if_gnt=%0d ls_gnt=%0d if_rv=%0d ls_rv=%0d addr=%h lat=%0d unstable=%0d, %0d sub-checks wrong",
                         t, exp_if ? "IF" : "LS", kill_on, obs_if_gnt, obs_ls_gnt, obs_if_rv,
                         obs_ls_rv, obs_addr, obs_lat, obs_unstable, bad);
            end
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_starvation();
        test_store();
        test_kill();
        test_spurious_rvalid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
